// File: rtl/op_pkg.sv
// Shared operation encoding, scheduler state encoding and per-op latency lookup.
package op_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned LAT_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MUL = 2'd3
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_t;

    // Latencies are passed in so each scheduler instance can carry its own parameters.
    function automatic logic [LAT_W-1:0] op_latency(
        input operation_t  op,
        input int unsigned add_lat,
        input int unsigned sub_lat,
        input int unsigned mul_lat
    );
        logic [LAT_W-1:0] lat;
        case (op)
            OP_ADD:  lat = LAT_W'(add_lat);
            OP_SUB:  lat = LAT_W'(sub_lat);
            OP_MUL:  lat = LAT_W'(mul_lat);
            default: lat = LAT_W'(1);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/op_issue_sched_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves past the winner only on a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/op_issue_sched.sv
// Arbitrates two producers into the op FIFO and issues head ops to the execution unit.
module op_issue_sched
    import op_pkg::*;
#(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned SUB_LAT = 1,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  operation_t       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  operation_t       req1_op,
    output logic             req1_ready,
    output logic             fifo_push,
    output operation_t       fifo_wdata,
    output logic             fifo_pop,
    output logic             fifo_flush,
    input  operation_t       fifo_rdata,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic             flush_req,
    output logic             exu_start,
    output operation_t       exu_op,
    output logic             op_done,
    output logic             busy,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] nop_drop_cnt
);

    sched_state_t     state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    operation_t       exu_op_q, exu_op_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] nop_cnt_q, nop_cnt_d;

    logic       head_take;
    logic       push_en;
    logic [1:0] gnt;

    // Strobes are held low while reset is sampled so nothing leaks out during reset.
    assign head_take  = !rst && !flush_req && (state_q == ST_IDLE) && !fifo_empty;
    assign fifo_pop   = head_take;
    assign exu_start  = head_take && (fifo_rdata != OP_NOP);
    assign op_done    = !rst && !flush_req && (state_q == ST_BUSY) && (lat_q == '0);
    assign fifo_flush = !rst && flush_req;

    // The FIFO drops a push in a pop cycle, so never offer one then.
    assign push_en = !rst && !flush_req && (state_q != ST_FLUSH) && !fifo_full && !fifo_pop;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push_en),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign fifo_push  = |gnt;
    assign fifo_wdata = gnt[1] ? req1_op : (gnt[0] ? req0_op : OP_NOP);

    assign exu_op       = exu_op_q;
    assign busy         = busy_q;
    assign issue_cnt    = issue_cnt_q;
    assign nop_drop_cnt = nop_cnt_q;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        exu_op_d    = exu_op_q;
        issue_cnt_d = issue_cnt_q;
        nop_cnt_d   = nop_cnt_q;
        if (flush_req) begin
            state_d  = ST_FLUSH;
            exu_op_d = OP_NOP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (fifo_rdata == OP_NOP) begin
                            nop_cnt_d = nop_cnt_q + CNT_W'(1);
                        end else begin
                            state_d     = ST_BUSY;
                            exu_op_d    = fifo_rdata;
                            issue_cnt_d = issue_cnt_q + CNT_W'(1);
                            lat_d       = op_latency(fifo_rdata, ADD_LAT, SUB_LAT, MUL_LAT)
                                          - LAT_W'(1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (lat_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            exu_op_q    <= OP_NOP;
            busy_q      <= 1'b0;
            issue_cnt_q <= '0;
            nop_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            exu_op_q    <= exu_op_d;
            busy_q      <= busy_d;
            issue_cnt_q <= issue_cnt_d;
            nop_cnt_q   <= nop_cnt_d;
        end
    end

endmodule

// File: tb/tb_op_issue_sched.sv
// Directed bench for op_issue_sched; the bench drives the FIFO-side inputs directly.
module tb_op_issue_sched;
    import op_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    operation_t       req0_op, req1_op;
    logic             req0_ready, req1_ready;
    logic             fifo_push, fifo_pop, fifo_flush;
    operation_t       fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             flush_req;
    logic             exu_start, op_done, busy;
    operation_t       exu_op;
    logic [CNT_W-1:0] issue_cnt, nop_drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ptr;

    always #5 clk = ~clk;

    op_issue_sched #(.ADD_LAT(1), .SUB_LAT(1), .MUL_LAT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_op      (req0_op),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_op      (req1_op),
        .req1_ready   (req1_ready),
        .fifo_push    (fifo_push),
        .fifo_wdata   (fifo_wdata),
        .fifo_pop     (fifo_pop),
        .fifo_flush   (fifo_flush),
        .fifo_rdata   (fifo_rdata),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .flush_req    (flush_req),
        .exu_start    (exu_start),
        .exu_op       (exu_op),
        .op_done      (op_done),
        .busy         (busy),
        .issue_cnt    (issue_cnt),
        .nop_drop_cnt (nop_drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = OP_NOP; req1_op = OP_NOP; fifo_rdata = OP_NOP;
        fifo_full = 1'b0; fifo_empty = 1'b1; flush_req = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_issue_cnt", 32'(issue_cnt), 0);
        check("rst_nop_cnt", 32'(nop_drop_cnt), 0);
        check("rst_exu_op", 32'(exu_op), 32'(OP_NOP));
        check("rst_busy", 32'(busy), 0);

        // req0 pushes add into an empty FIFO, then it is popped and issued
        req0_valid = 1'b1; req0_op = OP_ADD;
        #1;
        check("t1_req0_ready", 32'(req0_ready), 1);
        check("t1_req1_ready", 32'(req1_ready), 0);
        check("t1_push", 32'(fifo_push), 1);
        check("t1_wdata", 32'(fifo_wdata), 32'(OP_ADD));
        step();
        req0_valid = 1'b0; fifo_empty = 1'b0; fifo_rdata = OP_ADD;
        #1;
        check("t1_pop", 32'(fifo_pop), 1);
        check("t1_start", 32'(exu_start), 1);
        check("t1_no_push", 32'(fifo_push), 0);
        step();
        fifo_empty = 1'b1;
        #1;
        check("t1_done", 32'(op_done), 1);
        check("t1_exu_op", 32'(exu_op), 32'(OP_ADD));
        check("t1_busy", 32'(busy), 1);
        check("t1_issue_cnt", 32'(issue_cnt), 1);
        step();
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_done", 32'(op_done), 0);

        // mul then sub: mul done at t+4, sub issued t+5 and done t+6
        fifo_empty = 1'b0; fifo_rdata = OP_MUL;
        #1;
        check("t2_mul_start", 32'(exu_start), 1);
        step();
        fifo_rdata = OP_SUB;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check("t2_mul_wait_done", 32'(op_done), 0);
            check("t2_mul_wait_pop", 32'(fifo_pop), 0);
            step();
        end
        #1;
        check("t2_mul_done", 32'(op_done), 1);
        step();
        check("t2_sub_start", 32'(exu_start), 1);
        check("t2_exu_held", 32'(exu_op), 32'(OP_MUL));
        step();
        fifo_empty = 1'b1;
        #1;
        check("t2_sub_done", 32'(op_done), 1);
        check("t2_exu_sub", 32'(exu_op), 32'(OP_SUB));
        check("t2_issue_cnt", 32'(issue_cnt), 3);
        step();

        // nop, nop, add: nops dropped one per cycle
        fifo_empty = 1'b0; fifo_rdata = OP_NOP;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_nop_pop", 32'(fifo_pop), 1);
            check("t3_nop_start", 32'(exu_start), 0);
            step();
        end
        fifo_rdata = OP_ADD;
        #1;
        check("t3_add_start", 32'(exu_start), 1);
        check("t3_nop_cnt", 32'(nop_drop_cnt), 2);
        step();
        fifo_empty = 1'b1;
        #1;
        check("t3_done", 32'(op_done), 1);
        check("t3_issue_cnt", 32'(issue_cnt), 4);
        step();

        // Both producers valid: grants alternate; pop or full cycles grant nothing
        exp_ptr = 1;
        req0_valid = 1'b1; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_op = OP_SUB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_rdy0", 32'(req0_ready), 32'(exp_ptr == 0));
            check("t4_rdy1", 32'(req1_ready), 32'(exp_ptr == 1));
            check("t4_wdata", 32'(fifo_wdata), (exp_ptr == 1) ? 32'(OP_SUB) : 32'(OP_ADD));
            step();
            exp_ptr = 1 - exp_ptr;
        end
        fifo_empty = 1'b0; fifo_rdata = OP_NOP;
        #1;
        check("t4_pop_no_rdy0", 32'(req0_ready), 0);
        check("t4_pop_no_rdy1", 32'(req1_ready), 0);
        check("t4_pop_no_push", 32'(fifo_push), 0);
        step();
        fifo_empty = 1'b1; fifo_full = 1'b1;
        #1;
        check("t4_full_no_push", 32'(fifo_push), 0);
        step();
        fifo_full = 1'b0;
        #1;
        check("t4_ptr_kept0", 32'(req0_ready), 32'(exp_ptr == 0));
        check("t4_ptr_kept1", 32'(req1_ready), 32'(exp_ptr == 1));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Flush during the second cycle of a mul
        fifo_empty = 1'b0; fifo_rdata = OP_MUL;
        #1;
        check("t5_mul_start", 32'(exu_start), 1);
        step();
        fifo_empty = 1'b1; flush_req = 1'b1; req0_valid = 1'b1;
        #1;
        check("t5_flush", 32'(fifo_flush), 1);
        check("t5_flush_done", 32'(op_done), 0);
        check("t5_flush_pop", 32'(fifo_pop), 0);
        check("t5_flush_rdy0", 32'(req0_ready), 0);
        step();
        flush_req = 1'b0;
        #1;
        check("t5_fl_busy", 32'(busy), 1);
        check("t5_fl_rdy0", 32'(req0_ready), 0);
        check("t5_fl_push", 32'(fifo_push), 0);
        check("t5_fl_done", 32'(op_done), 0);
        check("t5_fl_exu_op", 32'(exu_op), 32'(OP_NOP));
        check("t5_fl_issue_cnt", 32'(issue_cnt), 5);
        check("t5_fl_nop_cnt", 32'(nop_drop_cnt), 3);
        step();
        check("t5_idle_busy", 32'(busy), 0);
        check("t5_idle_rdy0", 32'(req0_ready), 1);
        req0_valid = 1'b0;
        step();

        // Reset mid-BUSY with the FIFO full
        fifo_full = 1'b1; fifo_empty = 1'b0; fifo_rdata = OP_MUL;
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_pop", 32'(fifo_pop), 0);
        check("t6_rst_done", 32'(op_done), 0);
        step();
        check("t6_issue_cnt", 32'(issue_cnt), 0);
        check("t6_nop_cnt", 32'(nop_drop_cnt), 0);
        check("t6_exu_op", 32'(exu_op), 32'(OP_NOP));
        check("t6_busy", 32'(busy), 0);
        check("t6_strobes", 32'({fifo_pop, fifo_push, fifo_flush, exu_start, op_done,
                                 req0_ready, req1_ready}), 0);
        rst = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("t6_idle_done", 32'(op_done), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
